// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: the canonical NOP, instruction size and fetch FSM states.
package riscv_pkg;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam int          INSTR_BYTES = 4;

  typedef enum logic [0:0] {
    FETCH_RUN   = 1'b0,
    FETCH_DRAIN = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer with clear and two-entry peek (head and head+1).
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           head_data,
  output logic [WIDTH-1:0]           next_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_next;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push && !clear && (count_q != CW'(DEPTH));
    do_pop   = pop && !clear && (count_q != '0);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign rd_next   = rd_ptr_q + 1'b1;
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];
  assign next_data = mem_q[rd_next];
endmodule

// File: rtl/fetch_cycle.sv
// Fetch stage: owns the fetch PC, issues credit-limited in-order memory requests,
// buffers returned words and drops stale responses after a redirect.
module fetch_cycle import riscv_pkg::*; #(
  parameter int              XLEN               = 64,
  parameter int              INSTRUCTION_LENGTH = XLEN/2,
  parameter logic [XLEN-1:0] RESET_PC           = '0,
  parameter int              FIFO_DEPTH         = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          imem_req_valid,
  input  logic                          imem_req_ready,
  output logic [XLEN-1:0]               imem_req_addr,
  input  logic                          imem_resp_valid,
  input  logic [INSTRUCTION_LENGTH-1:0] imem_resp_data,
  input  logic                          redirect_valid,
  input  logic [XLEN-1:0]               redirect_pc,
  input  logic                          f_to_d_enable_ff,
  output logic                          fetch_valid,
  output logic [INSTRUCTION_LENGTH-1:0] instruction,
  output logic [INSTRUCTION_LENGTH-1:0] next_instruction,
  output logic [XLEN-1:0]               PC_out,
  output fetch_state_e                  dbg_state
);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam logic [INSTRUCTION_LENGTH-1:0] NOP = INSTRUCTION_LENGTH'(NOP_INSTR);

  // Handshake: a request transfers on a cycle where imem_req_valid && imem_req_ready;
  // once raised, valid holds with a stable address until transfer unless a redirect arrives.
  fetch_state_e                  state_q, state_d;
  logic [XLEN-1:0]               fetch_pc_q, fetch_pc_d, head_pc_q, head_pc_d, target;
  logic [CW-1:0]                 outstanding_q, outstanding_d, discard_q, discard_d;
  logic [CW-1:0]                 fifo_count;
  logic [INSTRUCTION_LENGTH-1:0] head_word, next_word;
  logic                          credit_ok, req_fire, resp_fire, resp_drop, push, pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= FETCH_RUN;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH_RUN:   if (discard_d != '0) state_d = FETCH_DRAIN;
      FETCH_DRAIN: if (discard_d == '0) state_d = FETCH_RUN;
    endcase
  end

  always_comb begin
    resp_drop = (state_q == FETCH_DRAIN);
    dbg_state = state_q;
  end

  always_comb begin
    target         = redirect_pc & ~XLEN'(3);
    credit_ok      = ({1'b0, fifo_count} + {1'b0, outstanding_q}) < (CW+1)'(FIFO_DEPTH);
    imem_req_valid = rst && credit_ok && !redirect_valid;
    imem_req_addr  = fetch_pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    // Responses nobody is waiting for (e.g. from before a reset) are ignored.
    resp_fire      = imem_resp_valid && (outstanding_q != '0);
    fetch_valid    = (fifo_count != '0);
    pop            = f_to_d_enable_ff && fetch_valid && !redirect_valid;
    push           = resp_fire && !resp_drop && !redirect_valid;
    fetch_pc_d     = fetch_pc_q;
    head_pc_d      = head_pc_q;
    outstanding_d  = outstanding_q;
    discard_d      = discard_q;
    if (redirect_valid) begin
      fetch_pc_d    = target;
      head_pc_d     = target;
      outstanding_d = outstanding_q - CW'(resp_fire);
      discard_d     = outstanding_q - CW'(resp_fire);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(INSTR_BYTES);
      if (pop)      head_pc_d  = head_pc_q + XLEN'(INSTR_BYTES);
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(resp_fire);
      discard_d     = discard_q - CW'(resp_fire && resp_drop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_PC;
      head_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      head_pc_q     <= head_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  fetch_fifo #(
    .WIDTH (INSTRUCTION_LENGTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect_valid),
    .push      (push),
    .pop       (pop),
    .push_data (imem_resp_data),
    .count     (fifo_count),
    .head_data (head_word),
    .next_data (next_word)
  );

  assign instruction      = fetch_valid ? head_word : NOP;
  assign next_instruction = (fifo_count >= CW'(2)) ? next_word : NOP;
  assign PC_out           = head_pc_q;

  resp_needs_request: assert property (@(posedge clk) disable iff (!rst)
    imem_resp_valid |-> (outstanding_q != '0));
endmodule

// File: tb/tb_fetch_cycle.sv
// Directed bench for fetch_cycle: vector table for streaming/redirect, hand sequences for the rest.
module tb_fetch_cycle;
  import riscv_pkg::*;

  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic                 clk, rst;
  logic                 imem_req_valid, imem_req_ready, imem_resp_valid;
  logic [63:0]          imem_req_addr, redirect_pc, PC_out;
  logic [31:0]          imem_resp_data, instruction, next_instruction;
  logic                 redirect_valid, f_to_d_enable_ff, fetch_valid;
  fetch_state_e         dbg_state;

  fetch_cycle dut (
    .clk              (clk),
    .rst              (rst),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_req_addr    (imem_req_addr),
    .imem_resp_valid  (imem_resp_valid),
    .imem_resp_data   (imem_resp_data),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .f_to_d_enable_ff (f_to_d_enable_ff),
    .fetch_valid      (fetch_valid),
    .instruction      (instruction),
    .next_instruction (next_instruction),
    .PC_out           (PC_out),
    .dbg_state        (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat   = 1;

  logic [63:0] pend_a[$];
  int          pend_due[$];
  logic [63:0] exp_q[$];

  logic        s_req_v, s_fv;
  logic [63:0] s_addr, s_pc;
  logic [31:0] s_ins, s_nxt;
  logic [63:0] s_state;

  function automatic logic [31:0] w(input logic [63:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: snapshot outputs at negedge, advance, then update the memory model.
  task automatic tick();
    logic acc, rf;
    logic [63:0] a;
    @(negedge clk);
    s_req_v = imem_req_valid; s_addr = imem_req_addr; s_fv = fetch_valid;
    s_pc = PC_out; s_ins = instruction; s_nxt = next_instruction; s_state = 64'(dbg_state);
    acc = imem_req_valid && imem_req_ready;
    a   = imem_req_addr;
    rf  = imem_resp_valid;
    @(posedge clk);
    #1;
    cyc++;
    if (!rst) begin
      pend_a.delete();
      pend_due.delete();
    end else begin
      if (rf && pend_a.size() > 0) begin
        void'(pend_a.pop_front());
        void'(pend_due.pop_front());
      end
      if (acc) begin
        pend_a.push_back(a);
        pend_due.push_back(cyc + lat - 1);
      end
    end
    if (pend_a.size() > 0 && pend_due[0] <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = w(pend_a[0]);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    imem_resp_valid = 1'b0;
    pend_a.delete();
    pend_due.delete();
    tick();
    rst = 1'b1;
  endtask

  // Pull deliveries (fetch_valid && enable) against exp_q within a cycle budget.
  task automatic drain_check(input string name, input int budget, input bit rand_ready);
    logic [63:0] e;
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      if (rand_ready) imem_req_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
      if (s_fv && f_to_d_enable_ff) begin
        e = exp_q.pop_front();
        chk({name, "_pc"}, s_pc, e);
        chk({name, "_ins"}, 64'(s_ins), 64'(w(e)));
      end
    end
    chk({name, "_left"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  typedef struct {
    logic        en;
    logic        redir;
    logic [63:0] rpc;
    logic        req_v;
    logic [63:0] addr;
    logic        fv;
    logic [63:0] pc;
    logic [31:0] ins;
    logic [31:0] nxt;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int nreq;

    // 1-cycle memory stream, fill with stall, then redirect coinciding with pop and response
    vecs[0]  = '{1'b0, 1'b0, 64'h0,   1'b1, 64'h0,   1'b0, 64'h0,   NOP_W,      NOP_W};
    vecs[1]  = '{1'b0, 1'b0, 64'h0,   1'b1, 64'h4,   1'b0, 64'h0,   NOP_W,      NOP_W};
    vecs[2]  = '{1'b0, 1'b0, 64'h0,   1'b1, 64'h8,   1'b1, 64'h0,   w(0),       NOP_W};
    vecs[3]  = '{1'b1, 1'b0, 64'h0,   1'b1, 64'hC,   1'b1, 64'h0,   w(0),       w(4)};
    vecs[4]  = '{1'b1, 1'b0, 64'h0,   1'b1, 64'h10,  1'b1, 64'h4,   w(4),       w(8)};
    vecs[5]  = '{1'b1, 1'b0, 64'h0,   1'b1, 64'h14,  1'b1, 64'h8,   w(8),       w(64'hC)};
    vecs[6]  = '{1'b1, 1'b0, 64'h0,   1'b1, 64'h18,  1'b1, 64'hC,   w(64'hC),   w(64'h10)};
    vecs[7]  = '{1'b1, 1'b0, 64'h0,   1'b1, 64'h1C,  1'b1, 64'h10,  w(64'h10),  w(64'h14)};
    vecs[8]  = '{1'b1, 1'b1, 64'h202, 1'b0, 64'h20,  1'b1, 64'h14,  w(64'h14),  w(64'h18)};
    vecs[9]  = '{1'b1, 1'b0, 64'h0,   1'b1, 64'h200, 1'b0, 64'h200, NOP_W,      NOP_W};
    vecs[10] = '{1'b1, 1'b0, 64'h0,   1'b1, 64'h204, 1'b0, 64'h200, NOP_W,      NOP_W};
    vecs[11] = '{1'b1, 1'b0, 64'h0,   1'b1, 64'h208, 1'b1, 64'h200, w(64'h200), NOP_W};
    vecs[12] = '{1'b1, 1'b0, 64'h0,   1'b1, 64'h20C, 1'b1, 64'h204, w(64'h204), NOP_W};

    rst = 1'b0; imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; f_to_d_enable_ff = 1'b0;

    // reset state
    tick();
    chk("rst_req_v", 64'(s_req_v), 64'd0);
    chk("rst_fv", 64'(s_fv), 64'd0);
    chk("rst_ins", 64'(s_ins), 64'(NOP_W));
    chk("rst_nxt", 64'(s_nxt), 64'(NOP_W));
    chk("rst_pc", s_pc, 64'h0);
    chk("rst_state", s_state, 64'(FETCH_RUN));
    rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      f_to_d_enable_ff = vecs[i].en;
      redirect_valid   = vecs[i].redir;
      redirect_pc      = vecs[i].rpc;
      tick();
      chk($sformatf("v%0d_req_v", i), 64'(s_req_v), 64'(vecs[i].req_v));
      chk($sformatf("v%0d_addr", i), s_addr, vecs[i].addr);
      chk($sformatf("v%0d_fv", i), 64'(s_fv), 64'(vecs[i].fv));
      chk($sformatf("v%0d_pc", i), s_pc, vecs[i].pc);
      chk($sformatf("v%0d_ins", i), 64'(s_ins), 64'(vecs[i].ins));
      chk($sformatf("v%0d_nxt", i), 64'(s_nxt), 64'(vecs[i].nxt));
    end
    redirect_valid = 1'b0;

    // backpressure: stall 10 cycles, then release with random ready
    do_reset();
    lat = 1; f_to_d_enable_ff = 1'b0; imem_req_ready = 1'b1;
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (s_req_v && imem_req_ready) nreq++;
    end
    chk("bp_reqs", 64'(nreq), 64'd4);
    chk("bp_fv", 64'(s_fv), 64'd1);
    chk("bp_pc", s_pc, 64'h0);
    chk("bp_ins", 64'(s_ins), 64'(w(0)));
    chk("bp_nxt", 64'(s_nxt), 64'(w(4)));
    f_to_d_enable_ff = 1'b1;
    for (int i = 0; i < 12; i++) exp_q.push_back(64'(i * 4));
    drain_check("bp", 80, 1'b1);

    // asynchronous reset in the middle of traffic
    imem_req_ready = 1'b1; lat = 3; f_to_d_enable_ff = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    imem_resp_valid = 1'b0;
    #1;
    chk("mrst_req_v", 64'(imem_req_valid), 64'd0);
    chk("mrst_fv", 64'(fetch_valid), 64'd0);
    chk("mrst_ins", 64'(instruction), 64'(NOP_W));
    chk("mrst_nxt", 64'(next_instruction), 64'(NOP_W));
    chk("mrst_pc", PC_out, 64'h0);
    pend_a.delete();
    pend_due.delete();
    tick();
    rst = 1'b1;

    // redirect with three requests in flight on a slow memory
    lat = 4; f_to_d_enable_ff = 1'b1;
    tick();
    chk("restart_req_v", 64'(s_req_v), 64'd1);
    chk("restart_addr", s_addr, 64'h0);
    tick();
    tick();
    redirect_valid = 1'b1; redirect_pc = 64'h102;
    tick();
    chk("redir_req_v", 64'(s_req_v), 64'd0);
    redirect_valid = 1'b0;
    tick();
    chk("drain_req_v", 64'(s_req_v), 64'd1);
    chk("drain_addr", s_addr, 64'h100);
    chk("drain_state", s_state, 64'(FETCH_DRAIN));
    for (int i = 0; i < 4; i++) exp_q.push_back(64'h100 + 64'(i * 4));
    drain_check("redir", 40, 1'b0);
    chk("redir_state_end", 64'(dbg_state), 64'(FETCH_RUN));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
